// File: rtl/jpeg_pkg.sv
// Shared types and constants for the JPEG output-stream unpacker.
package jpeg_pkg;
   localparam int WORD_W = 32;
   localparam int NUM_CH = 3;

   typedef enum logic [1:0] {
      TAG_NONE = 2'b00,
      TAG_Y    = 2'b01,
      TAG_CB   = 2'b10,
      TAG_CR   = 2'b11
   } chan_tag_e;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } shift_state_e;
endpackage

// File: rtl/jpeg_chan_serializer.sv
// One channel: word FIFO feeding a 32-bit MSB-first shifter on a 1-bit valid/ready stream,
// with a saturating accepted-bit counter and a sticky overflow flag.
module jpeg_chan_serializer
   import jpeg_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [WORD_W-1:0] wr_data,
   input  logic              bit_ready,
   output logic              bit_out,
   output logic              bit_valid,
   output logic              fifo_empty,
   output logic              overflow,
   output logic [CNT_W-1:0]  bits_sent
);
   localparam int AW = $clog2(DEPTH);

   logic [WORD_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [AW:0]       count, count_nxt;
   logic [WORD_W-1:0] shreg;
   logic [4:0]        idx;
   shift_state_e      state, state_nxt;

   logic xfer, last, fifo_ne, full, pop, push, drop;

   assign bit_valid = (state == ST_SHIFT);
   assign bit_out   = shreg[WORD_W-1];
   assign xfer      = bit_valid & bit_ready;
   assign last      = xfer & (idx == 5'd31);
   assign fifo_ne   = (count != '0);
   assign full      = (count == (AW+1)'(DEPTH));
   // Reloading the shifter frees a slot in the same cycle, so a full FIFO can still accept.
   assign pop       = fifo_ne & ((state == ST_IDLE) | last);
   assign push      = wr_en & (~full | pop);
   assign drop      = wr_en & full & ~pop;

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (pop) state_nxt = ST_SHIFT;
         ST_SHIFT: if (last && !fifo_ne) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      count_nxt = count;
      case ({push, pop})
         2'b10:   count_nxt = count + 1'b1;
         2'b01:   count_nxt = count - 1'b1;
         default: count_nxt = count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Storage carries no reset; occupancy is tracked by pointers and count.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         shreg      <= '0;
         idx        <= '0;
         fifo_empty <= 1'b1;
         overflow   <= 1'b0;
         bits_sent  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            shreg  <= mem[rd_ptr];
            idx    <= '0;
            rd_ptr <= rd_ptr + 1'b1;
         end else if (xfer) begin
            shreg <= {shreg[WORD_W-2:0], 1'b0};
            idx   <= idx + 1'b1;
         end
         count      <= count_nxt;
         fifo_empty <= (count_nxt == '0) && (state_nxt == ST_IDLE);
         overflow   <= overflow | drop;
         if (xfer && !(&bits_sent)) bits_sent <= bits_sent + 1'b1;
      end
   end
endmodule

// File: rtl/jpeg_stream_unpacker.sv
// Demultiplexes tagged jpeg_top output words onto three independent serial channels (Y, Cb, Cr).
module jpeg_stream_unpacker
   import jpeg_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [WORD_W-1:0]       jpeg_bitstream,
   input  logic [1:0]              data_valid,
   output logic [NUM_CH-1:0]       bit_out,
   output logic [NUM_CH-1:0]       bit_valid,
   input  logic [NUM_CH-1:0]       bit_ready,
   output logic [NUM_CH-1:0]       fifo_empty,
   output logic [NUM_CH-1:0]       overflow,
   output logic [NUM_CH*CNT_W-1:0] bits_sent
);
   chan_tag_e         tag;
   logic [NUM_CH-1:0] wr_en;

   assign tag = chan_tag_e'(data_valid);

   always_comb begin
      wr_en = '0;
      case (tag)
         TAG_Y:   wr_en[0] = 1'b1;
         TAG_CB:  wr_en[1] = 1'b1;
         TAG_CR:  wr_en[2] = 1'b1;
         default: wr_en = '0;
      endcase
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
      jpeg_chan_serializer #(
         .DEPTH (DEPTH),
         .CNT_W (CNT_W)
      ) u_chan (
         .clk        (clk),
         .rst        (rst),
         .wr_en      (wr_en[g]),
         .wr_data    (jpeg_bitstream),
         .bit_ready  (bit_ready[g]),
         .bit_out    (bit_out[g]),
         .bit_valid  (bit_valid[g]),
         .fifo_empty (fifo_empty[g]),
         .overflow   (overflow[g]),
         .bits_sent  (bits_sent[g*CNT_W +: CNT_W])
      );
   end
endmodule

// File: tb/tb_jpeg_stream_unpacker.sv
// Scoreboard bench: stimulus queues expected serial bits per channel, a negedge monitor
// pops and compares every accepted bit; directed checks cover status and timing.
module tb_jpeg_stream_unpacker;
   localparam int DEPTH = 4;
   localparam int CNT_W = 16;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [31:0]       jpeg_bitstream = '0;
   logic [1:0]        data_valid = '0;
   logic [2:0]        bit_out, bit_valid, fifo_empty, overflow;
   logic [2:0]        bit_ready = '0;
   logic [3*CNT_W-1:0] bits_sent;

   int checks = 0;
   int failures = 0;
   logic exp_q [3][$];

   jpeg_stream_unpacker #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk            (clk),
      .rst            (rst),
      .jpeg_bitstream (jpeg_bitstream),
      .data_valid     (data_valid),
      .bit_out        (bit_out),
      .bit_valid      (bit_valid),
      .bit_ready      (bit_ready),
      .fifo_empty     (fifo_empty),
      .overflow       (overflow),
      .bits_sent      (bits_sent)
   );

   always #5 clk = ~clk;

   // Monitor: a bit transfers at the next posedge whenever valid & ready are seen here.
   always @(negedge clk) begin
      if (!rst) begin
         for (int c = 0; c < 3; c++) begin
            if (bit_valid[c] && bit_ready[c]) begin
               checks++;
               if (exp_q[c].size() == 0) begin
                  failures++;
                  $display("FAIL stray_bit ch%0d got %0b required no bit", c, bit_out[c]);
               end else begin
                  logic e;
                  e = exp_q[c].pop_front();
                  if (bit_out[c] !== e) begin
                     failures++;
                     $display("FAIL stream_bit ch%0d got %0b required %0b", c, bit_out[c], e);
                  end
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s got %0h required %0h", name, act, req);
      end
   endtask

   task automatic flush();
      for (int c = 0; c < 3; c++) exp_q[c].delete();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      data_valid = '0;
      bit_ready = '0;
      tick();
      tick();
      rst = 1'b0;
      flush();
   endtask

   task automatic queue_word(input int ch, input logic [31:0] w);
      for (int i = 31; i >= 0; i--) exp_q[ch].push_back(w[i]);
   endtask

   // Drives one word for one edge; 'keep' says whether the bench expects it to be accepted.
   task automatic write_word(input int ch, input logic [31:0] w, input bit keep);
      data_valid = 2'(ch + 1);
      jpeg_bitstream = w;
      if (keep) queue_word(ch, w);
      tick();
      data_valid = '0;
   endtask

   task automatic wait_drain(input string name, input int limit);
      bit done;
      done = 1'b0;
      for (int i = 0; i < limit && !done; i++) begin
         if (fifo_empty == 3'b111 && bit_valid == 3'b000 &&
             exp_q[0].size() == 0 && exp_q[1].size() == 0 && exp_q[2].size() == 0)
            done = 1'b1;
         else
            tick();
      end
      chk(name, 64'(done), 64'd1);
   endtask

   initial begin
      int sent [3];
      bit  all_sent;
      logic [31:0] w;

      // Reset values
      do_reset();
      chk("rst_bit_valid", 64'(bit_valid), 64'h0);
      chk("rst_bit_out", 64'(bit_out), 64'h0);
      chk("rst_fifo_empty", 64'(fifo_empty), 64'h7);
      chk("rst_overflow", 64'(overflow), 64'h0);
      chk("rst_bits_sent", 64'(bits_sent), 64'h0);

      // Single word on Y, ready only on Y
      bit_ready = 3'b001;
      write_word(0, 32'h8000_0001, 1'b1);
      chk("single_valid_at_N", 64'(bit_valid[0]), 64'd0);
      chk("single_nonempty_at_N", 64'(fifo_empty[0]), 64'd0);
      tick();
      chk("single_valid_at_N1", 64'(bit_valid[0]), 64'd1);
      chk("single_msb_at_N1", 64'(bit_out[0]), 64'd1);
      wait_drain("single_drain", 200);
      chk("single_bits_sent_y", 64'(bits_sent[CNT_W-1:0]), 64'd32);
      chk("single_fifo_empty", 64'(fifo_empty), 64'h7);

      // Interleaved tags, streams offset by one cycle each
      do_reset();
      bit_ready = 3'b111;
      write_word(0, 32'hDEAD_BEEF, 1'b1);
      write_word(1, 32'h1234_5678, 1'b1);
      write_word(2, 32'hF0F0_0F0F, 1'b1);
      chk("inter_valid_offset2", 64'(bit_valid), 64'h3);
      tick();
      chk("inter_valid_offset3", 64'(bit_valid), 64'h7);
      wait_drain("inter_drain", 200);
      chk("inter_bits_sent", 64'(bits_sent), {16'd0, 16'd32, 16'd32, 16'd32});

      // Overflow: five Cb words fit, sixth dropped
      do_reset();
      for (int i = 0; i < 6; i++) write_word(1, 32'hC000_0000 + 32'(i * 32'h0101_1011), i < 5);
      chk("ovf_flag", 64'(overflow), 64'h2);
      chk("ovf_fifo_empty", 64'(fifo_empty), 64'h5);
      bit_ready = 3'b111;
      wait_drain("ovf_drain", 400);
      chk("ovf_bits_sent_cb", 64'(bits_sent[2*CNT_W-1:CNT_W]), 64'd160);
      chk("ovf_sticky", 64'(overflow), 64'h2);

      // Full FIFO with a reload on the same edge as the write
      do_reset();
      for (int i = 0; i < 5; i++) write_word(1, 32'hA000_0005 ^ 32'(i << 8), 1'b1);
      chk("fwp_no_ovf_pre", 64'(overflow), 64'h0);
      bit_ready = 3'b010;
      for (int i = 0; i < 31; i++) tick();
      write_word(1, 32'h5A5A_C3C3, 1'b1);
      chk("fwp_no_ovf", 64'(overflow), 64'h0);
      chk("fwp_no_bubble", 64'(bit_valid[1]), 64'd1);
      wait_drain("fwp_drain", 400);
      chk("fwp_bits_sent_cb", 64'(bits_sent[2*CNT_W-1:CNT_W]), 64'd192);
      chk("fwp_no_ovf_end", 64'(overflow), 64'h0);

      // Random stalls, 64 words per channel, writes throttled by outstanding bits
      do_reset();
      for (int c = 0; c < 3; c++) sent[c] = 0;
      all_sent = 1'b0;
      for (int cyc = 0; cyc < 40000 && !all_sent; cyc++) begin
         int ch;
         ch = cyc % 3;
         bit_ready = 3'($urandom);
         if (sent[ch] < 64 && exp_q[ch].size() <= 32 * DEPTH) begin
            w = $urandom;
            sent[ch]++;
            write_word(ch, w, 1'b1);
         end else begin
            tick();
         end
         all_sent = (sent[0] == 64) && (sent[1] == 64) && (sent[2] == 64);
      end
      chk("rand_all_written", 64'(all_sent), 64'd1);
      bit_ready = 3'b111;
      wait_drain("rand_drain", 1000);
      chk("rand_bits_sent", 64'(bits_sent), {16'd0, 16'd2048, 16'd2048, 16'd2048});
      chk("rand_no_ovf", 64'(overflow), 64'h0);

      // Reset mid-word
      do_reset();
      bit_ready = 3'b001;
      write_word(0, 32'hA5A5_1234, 1'b1);
      for (int i = 0; i < 10; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      flush();
      chk("mid_rst_bit_valid", 64'(bit_valid), 64'h0);
      chk("mid_rst_bit_out", 64'(bit_out), 64'h0);
      chk("mid_rst_fifo_empty", 64'(fifo_empty), 64'h7);
      chk("mid_rst_overflow", 64'(overflow), 64'h0);
      chk("mid_rst_bits_sent", 64'(bits_sent), 64'h0);
      write_word(0, 32'hC000_0003, 1'b1);
      tick();
      chk("post_rst_msb", 64'(bit_out[0]), 64'd1);
      wait_drain("post_rst_drain", 200);
      chk("post_rst_bits_sent_y", 64'(bits_sent[CNT_W-1:0]), 64'd32);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
